// File: rtl/sdram_write.sv
// sdram_write: SDRAM write-path command sequencer.
// Fills one row per trigger with seamless bursts and yields to refresh.
module sdram_write #(
    parameter int ROW_W  = 12,
    parameter int COL_W  = 9,
    parameter int BANK_W = 2,
    parameter int DATA_W = 16,
    parameter int BURST  = 4,
    parameter int TRCD   = 2,
    parameter int TRP    = 2
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              wr_trig,
    input  logic              wr_en,
    input  logic              ref_req,
    output logic              wr_req,
    output logic              wr_end,
    output logic [3:0]        wr_cmd,
    output logic [BANK_W-1:0] wr_bank,
    output logic [ROW_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_dq,
    output logic              wr_dq_oe,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_data
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);
    localparam logic [COL_W-1:0]  COL_STEP  = COL_W'(BURST);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'((1 << COL_W) - BURST);
    localparam logic [7:0] TRCD_LAST = 8'((TRCD > 1) ? (TRCD - 2) : 0);
    localparam logic [7:0] TRP_LAST  = 8'(TRP - 1);
    localparam logic [ROW_W-1:0] PRE_ADDR = ROW_W'(1 << 10);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACT,
        S_TRCD,
        S_WR,
        S_PRE,
        S_TRP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]        cnt;
    logic [BEAT_W-1:0] beat;
    logic [COL_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [BANK_W-1:0] bank_cnt;
    logic              trig_pending;
    logic              resume;
    logic              beat_last;
    logic              col_last;

    assign beat_last = (beat == BEAT_LAST);
    assign col_last  = (col_cnt == COL_LAST);

    always_comb begin
        state_nxt = state;
        wr_req    = 1'b0;
        wr_cmd    = CMD_NOP;
        wr_bank   = '0;
        wr_addr   = '0;
        wr_dq_oe  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (trig_pending || resume)
                    state_nxt = S_REQ;
            end
            S_REQ: begin
                wr_req = 1'b1;
                if (wr_en)
                    state_nxt = S_ACT;
            end
            S_ACT: begin
                wr_cmd    = CMD_ACT;
                wr_addr   = row_cnt;
                wr_bank   = bank_cnt;
                state_nxt = (TRCD > 1) ? S_TRCD : S_WR;
            end
            S_TRCD: begin
                if (cnt == TRCD_LAST)
                    state_nxt = S_WR;
            end
            S_WR: begin
                wr_dq_oe = 1'b1;
                wr_bank  = bank_cnt;
                if (beat == '0) begin
                    wr_cmd  = CMD_WR;
                    wr_addr = ROW_W'(col_cnt);
                end
                // refresh is honoured only once the burst is complete
                if (beat_last && (col_last || ref_req))
                    state_nxt = S_PRE;
            end
            S_PRE: begin
                wr_cmd    = CMD_PRE;
                wr_addr   = PRE_ADDR;
                wr_bank   = bank_cnt;
                state_nxt = S_TRP;
            end
            S_TRP: begin
                if (cnt == TRP_LAST)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign fifo_rd = wr_dq_oe;
    assign wr_dq   = wr_dq_oe ? fifo_data : '0;

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            beat         <= '0;
            col_cnt      <= '0;
            row_cnt      <= '0;
            bank_cnt     <= '0;
            trig_pending <= 1'b0;
            resume       <= 1'b0;
            wr_end       <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
            wr_end <= (state == S_TRP) && (state_nxt == S_IDLE);

            // a new trigger wins over the clear so it queues one more row
            if (wr_trig)
                trig_pending <= 1'b1;
            else if (state == S_ACT && !resume)
                trig_pending <= 1'b0;

            if (state == S_WR) begin
                beat <= beat_last ? '0 : beat + 1'b1;
                if (beat_last) begin
                    col_cnt <= col_cnt + COL_STEP;
                    if (col_last) begin
                        row_cnt <= row_cnt + 1'b1;
                        if (&row_cnt)
                            bank_cnt <= bank_cnt + 1'b1;
                        resume <= 1'b0;
                    end else if (ref_req) begin
                        resume <= 1'b1;
                    end
                end
            end else begin
                beat <= '0;
            end
        end
    end

endmodule

// File: doc/sdram_write.md
Name: sdram_write

Overview:
- Write-path command sequencer inside sdram_top, directly upstream of the SDRAM pins through the top-level arbiter. Sits beside the init and auto-refresh sequencers.
- On wr_trig it requests the bus and, once granted, fills one full SDRAM row with 4-beat bursts taken from a show-ahead FIFO. It then precharges and releases the bus.
- It yields to a pending auto-refresh at burst boundaries and resumes the same row afterwards.

Parameters:
- ROW_W, 12, row address width (drives sdram_addr width).
- COL_W, 9, column address width; one row = 2^COL_W words.
- BANK_W, 2, bank address width.
- DATA_W, 16, data width.
- BURST, 4, beats per WRITE command (fixed burst length; COL_W columns divisible by BURST).
- TRCD, 2, cycles from ACTIVE to first WRITE (min 1).
- TRP, 2, NOP cycles after PRECHARGE before bus release (min 1).

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- s_rst  in  1  asynchronous, active-high reset.
- wr_trig  in  1  single-cycle pulse: write the next row.
- wr_en  in  1  arbiter grant; held high while this block owns the bus.
- ref_req  in  1  auto-refresh pending; write must yield at the next burst boundary.
- wr_req  out  1  bus request to arbiter.
- wr_end  out  1  one-cycle pulse: bus released (precharge and tRP done).
- wr_cmd  out  4  {cs_n,ras_n,cas_n,we_n}: NOP=0111, ACTIVE=0011, WRITE=0100, PRECHARGE=0010.
- wr_bank  out  BANK_W  bank address.
- wr_addr  out  ROW_W  row (ACTIVE) / column (WRITE) / A10=1 (PRECHARGE).
- wr_dq  out  DATA_W  write data; equals fifo_data while wr_dq_oe=1, else 0.
- wr_dq_oe  out  1  data-bus drive enable.
- fifo_rd  out  1  FIFO pop; equals wr_dq_oe.
- fifo_data  in  DATA_W  show-ahead FIFO head word.

Behaviour:
- Reset state:
  - State IDLE.
  - wr_cmd=0111; wr_req, wr_end, wr_dq_oe and fifo_rd are 0; wr_addr, wr_bank and wr_dq are 0.
  - Row counter, bank counter, column counter and trig_pending are 0.
- trig_pending:
  - Set by wr_trig in any state.
  - Cleared when ACTIVE is issued for a new row (not for a resumed row).
  - A wr_trig while busy queues exactly one further row; extra pulses merge into it.
- FSM states: IDLE -> REQ -> ACT -> TRCD -> WR -> PRE -> TRP -> IDLE or REQ.
- IDLE: go to REQ when trig_pending=1 or resume=1.
- REQ: wr_req=1. When wr_en is sampled high, the next cycle is ACT; wr_req drops in that same cycle.
- ACT:
  - One cycle; wr_cmd=ACTIVE, wr_addr=row counter, wr_bank=bank counter.
  - Followed by TRCD-1 NOP cycles, so the first WRITE comes exactly TRCD cycles after ACTIVE.
- WR:
  - Beat 0 issues WRITE with wr_addr={zero-pad, column counter}.
  - Beats 0..BURST-1 have wr_dq_oe=fifo_rd=1; write CAS latency is 0.
  - The column counter advances by BURST at beat BURST-1.
  - If columns remain and ref_req=0 at beat BURST-1, the next WRITE is issued on the following cycle (seamless, no gap).
  - Otherwise go to PRE.
- PRE: wr_cmd=PRECHARGE with wr_addr[10]=1, then TRP NOP cycles, then wr_end=1 for one cycle.
- Row complete (column counter wrapped to 0):
  - Row counter increments; on wrap from 2^ROW_W-1 to 0 the bank counter increments, and the bank counter itself wraps.
  - resume=0.
- Row interrupted by ref_req: resume=1, and the column counter and row are kept. The block returns via IDLE to REQ, re-ACTIVATEs the same row and continues at the saved column.
- ref_req arriving mid-burst never truncates a burst.
- ref_req high on the last burst of a row: the row counts as complete.
- wr_en dropping while owning the bus is illegal for the arbiter; the block ignores it and completes the current burst and precharge.
- s_rst mid-operation: immediate return to reset state; queued and resumed work is discarded.

Test Plan:
- Reset then idle 100 cycles -> wr_cmd=0111, wr_req=0, wr_dq_oe=0 throughout.
- wr_trig pulse, wr_en granted 3 cycles after wr_req rises -> ACTIVE at T with row 0 / bank 0. Then:
  - WRITE col 0 at T+2, col 4 at T+6 … col 508 at T+510.
  - 512 contiguous oe/fifo_rd cycles (T+2..T+513).
  - PRECHARGE with addr[10]=1 at T+514; wr_end at T+517.
- A second wr_trig during the first row -> exactly one more row, ACTIVE with row 1, no third row.
- ref_req raised at the beat 1 of col 100's burst -> burst finishes (col 100-103). Then:
  - PRECHARGE, wr_end.
  - After a re-grant, ACTIVE for the same row and the first WRITE at col 104; total beats for the row = 512.
- Preload row counter path by writing 4096 rows (or force) -> after row 4095 the next ACTIVE uses row 0, bank 1.
- s_rst asserted during a burst -> outputs reach reset values asynchronously; a later wr_trig starts row 0, bank 0, col 0.
